// File: rtl/obstacle_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | obstacle_lane: multi-slot obstacle spawner/scroller with a 2-cycle       |
// | sprite-ROM pixel lookup for the T-rex display layer mixer.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module obstacle_lane #(
  parameter int NUM_SLOTS   = 3,
  parameter int SCR_W       = 640,
  parameter int BIRD_OFFSET = 70,
  parameter int ANIM_FRAMES = 8,
  parameter int ADDR_W      = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           gamestate,
  input  logic                 frame_tick,
  input  logic [3:0]           speed,
  input  logic                 spawn_req,
  input  logic [3:0]           spawn_sel,
  input  logic [9:0]           spawn_y,
  output logic                 spawn_ack,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  output logic [ADDR_W-1:0]    rom_addr,
  output logic [2:0]           rom_sel,
  input  logic [15:0]          rom_data,
  output logic                 isempty_obstacle,
  output logic [11:0]          rgb_obstacle,
  output logic [NUM_SLOTS-1:0] active_mask
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W  = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_FRAMES - 1);

  localparam logic [1:0] GS_IDLE = 2'b00;
  localparam logic [1:0] GS_RUN  = 2'b01;

  localparam logic [3:0] SEL_C1S  = 4'd4;
  localparam logic [3:0] SEL_C1B  = 4'd5;
  localparam logic [3:0] SEL_C2S  = 4'd6;
  localparam logic [3:0] SEL_C2B  = 4'd7;
  localparam logic [3:0] SEL_BIRD = 4'd8;

  typedef enum logic {WING_UP = 1'b0, WING_DOWN = 1'b1} wing_e;

  function automatic logic signed [11:0] spr_w(input logic [3:0] s);
    case (s)
      SEL_C1S:  spr_w = 12'sd34;
      SEL_C1B:  spr_w = 12'sd50;
      SEL_C2S:  spr_w = 12'sd68;
      SEL_C2B:  spr_w = 12'sd100;
      SEL_BIRD: spr_w = 12'sd92;
      default:  spr_w = 12'sd0;
    endcase
  endfunction

  function automatic logic signed [11:0] spr_h(input logic [3:0] s);
    case (s)
      SEL_C1S, SEL_C2S: spr_h = 12'sd70;
      SEL_C1B, SEL_C2B: spr_h = 12'sd100;
      SEL_BIRD:         spr_h = 12'sd80;
      default:          spr_h = 12'sd0;
    endcase
  endfunction

  // Slot state
  logic [NUM_SLOTS-1:0]   valid_q, valid_d;
  logic [3:0]             sel_q [NUM_SLOTS];
  logic [3:0]             sel_d [NUM_SLOTS];
  logic signed [10:0]     ox_q  [NUM_SLOTS];
  logic signed [10:0]     ox_d  [NUM_SLOTS];
  logic [9:0]             oy_q  [NUM_SLOTS];
  logic [9:0]             oy_d  [NUM_SLOTS];

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  wing_e                  wing_q, wing_d;
  logic                   spawn_ack_q;

  logic [ADDR_W-1:0]      rom_addr_q;
  logic [2:0]             rom_sel_q;
  logic                   hit_q;
  logic                   isempty_q;
  logic [11:0]            rgb_q;

  // Per-slot combinational geometry
  logic signed [10:0]     w_mv    [NUM_SLOTS];
  logic                   w_retire[NUM_SLOTS];
  logic signed [11:0]     w_w     [NUM_SLOTS];
  logic signed [11:0]     w_h     [NUM_SLOTS];
  logic signed [11:0]     w_oxs   [NUM_SLOTS];
  logic signed [11:0]     w_row0  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   w_inside;

  logic signed [11:0]     w_xs, w_ys;
  assign w_xs = $signed({2'b00, x});
  assign w_ys = $signed({2'b00, y});

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign w_w[gi]      = spr_w(sel_q[gi]);
      assign w_h[gi]      = spr_h(sel_q[gi]);
      assign w_oxs[gi]    = {ox_q[gi][10], ox_q[gi]};
      assign w_row0[gi]   = $signed({2'b00, oy_q[gi]}) +
                            ((sel_q[gi] == SEL_BIRD) ? 12'(BIRD_OFFSET) : 12'sd0);
      assign w_mv[gi]     = ox_q[gi] - $signed({7'b0, speed});
      assign w_retire[gi] = ($signed({w_mv[gi][10], w_mv[gi]}) + w_w[gi]) <= 12'sd0;
      assign w_inside[gi] = valid_q[gi] &&
                            (w_xs >= w_oxs[gi]) && (w_xs < w_oxs[gi] + w_w[gi]) &&
                            (w_ys >= w_row0[gi]) && (w_ys < w_row0[gi] + w_h[gi]);
    end
  endgenerate

  // Lowest-index free slot for spawning
  logic              w_free_found;
  logic [SLOT_W-1:0] w_free_idx;
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = SLOT_W'(i);
      end
    end
  end

  logic w_sel_legal, w_spawn_ok;
  assign w_sel_legal = (spawn_sel >= SEL_C1S) && (spawn_sel <= SEL_BIRD);
  assign w_spawn_ok  = spawn_req && (gamestate == GS_RUN) && w_sel_legal && w_free_found;

  // The spawn target was free before this cycle, so it never collides with a move.
  always_comb begin
    valid_d = valid_q;
    sel_d   = sel_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    if (gamestate == GS_IDLE) begin
      valid_d = '0;
    end else if (gamestate == GS_RUN) begin
      if (frame_tick) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (valid_q[i]) begin
            ox_d[i] = w_mv[i];
            if (w_retire[i]) valid_d[i] = 1'b0;
          end
        end
      end
      if (w_spawn_ok) begin
        valid_d[w_free_idx] = 1'b1;
        sel_d[w_free_idx]   = spawn_sel;
        ox_d[w_free_idx]    = 11'(SCR_W);
        oy_d[w_free_idx]    = spawn_y;
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    wing_d = wing_q;
    if (gamestate == GS_IDLE) begin
      cnt_d  = '0;
      wing_d = WING_UP;
    end else if ((gamestate == GS_RUN) && frame_tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        wing_d = (wing_q == WING_UP) ? WING_DOWN : WING_UP;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Winning slot: the lowest index covering the pixel
  logic              w_hit;
  logic [SLOT_W-1:0] w_win;
  always_comb begin
    w_hit = 1'b0;
    w_win = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_inside[i]) begin
        w_hit = 1'b1;
        w_win = SLOT_W'(i);
      end
    end
  end

  logic signed [11:0] w_dx, w_dy, w_wd;
  logic [ADDR_W-1:0]  w_addr;
  logic [2:0]         w_bird_sel, w_rom_sel;
  assign w_wd   = w_w[w_win];
  assign w_dx   = w_xs - w_oxs[w_win];
  assign w_dy   = w_row0[w_win] + w_h[w_win] - 12'sd1 - w_ys;
  assign w_addr = ADDR_W'($unsigned(w_dx)) +
                  ADDR_W'($unsigned(w_dy)) * ADDR_W'($unsigned(w_wd));
  assign w_bird_sel = ((gamestate == GS_RUN) && (wing_q == WING_UP)) ? 3'd4 : 3'd5;

  always_comb begin
    w_rom_sel = 3'd0;
    case (sel_q[w_win])
      SEL_C1S:  w_rom_sel = 3'd0;
      SEL_C2S:  w_rom_sel = 3'd1;
      SEL_C1B:  w_rom_sel = 3'd2;
      SEL_C2B:  w_rom_sel = 3'd3;
      SEL_BIRD: w_rom_sel = w_bird_sel;
      default:  w_rom_sel = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        sel_q[i] <= '0;
        ox_q[i]  <= '0;
        oy_q[i]  <= '0;
      end
      cnt_q       <= '0;
      wing_q      <= WING_UP;
      spawn_ack_q <= 1'b0;
      rom_addr_q  <= '0;
      rom_sel_q   <= 3'd0;
      hit_q       <= 1'b0;
      isempty_q   <= 1'b1;
      rgb_q       <= 12'h000;
    end else begin
      valid_q     <= valid_d;
      sel_q       <= sel_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      cnt_q       <= cnt_d;
      wing_q      <= wing_d;
      spawn_ack_q <= w_spawn_ok;
      hit_q       <= w_hit;
      rom_addr_q  <= w_hit ? w_addr : '0;
      rom_sel_q   <= w_hit ? w_rom_sel : 3'd0;
      // Only opaque white or grey sprite pixels are drawn
      isempty_q   <= ~hit_q || (rom_data[3:0] != 4'hF) ||
                     !((rom_data[15:4] == 12'hFFF) || (rom_data[15:4] == 12'h555));
      rgb_q       <= rom_data[15:4];
    end
  end

  assign spawn_ack        = spawn_ack_q;
  assign rom_addr         = rom_addr_q;
  assign rom_sel          = rom_sel_q;
  assign isempty_obstacle = isempty_q;
  assign rgb_obstacle     = rgb_q;
  assign active_mask      = valid_q;

endmodule
`default_nettype wire

// File: doc/obstacle_lane.md
Name: obstacle_lane

Overview:
Multi-slot obstacle engine for the T-rex display path. Holds up to NUM_SLOTS live obstacles (small/big cactus, single/double, bird). Spawns them at the right screen edge, scrolls them left once per frame, retires them off the left edge and animates birds. Per VGA pixel it generates one sprite-ROM address and returns a registered rgb/transparency result to the layer mixer with fixed 2-cycle latency.

Parameters:
NUM_SLOTS, 3, number of concurrent obstacle slots (1..8)
SCR_W, 640, screen width; spawn x position
BIRD_OFFSET, 70, vertical offset of bird sprite below its slot y
ANIM_FRAMES, 8, frame ticks per bird wing-frame toggle (>=1)
ADDR_W, 14, sprite ROM address width

Ports:
clk  in  1  pixel/system clock
rst  in  1  synchronous active-high reset
gamestate  in  2  00 idle, 01 running, 10 game over
frame_tick  in  1  one-cycle pulse per frame (vblank)
speed  in  4  pixels moved per frame tick
spawn_req  in  1  request new obstacle (one-cycle pulse)
spawn_sel  in  4  0100 Cac1S, 0101 Cac1B, 0110 Cac2S, 0111 Cac2B, 1000 Bird
spawn_y  in  10  top row of new obstacle
spawn_ack  out  1  registered; high one cycle when spawn accepted
x  in  10  current pixel column
y  in  10  current pixel row
rom_addr  out  ADDR_W  registered sprite address
rom_sel  out  3  registered ROM select: 0 Cac1S, 1 Cac2S, 2 Cac1B, 3 Cac2B, 4 BirdUp, 5 BirdDown
rom_data  in  16  combinational ROM return for rom_addr/rom_sel, RGB444 in [15:4], alpha in [3:0]
isempty_obstacle  out  1  registered; 1 = pixel transparent
rgb_obstacle  out  12  registered pixel colour
active_mask  out  NUM_SLOTS  slot valid bits

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - All slots invalid; active_mask=0; spawn_ack=0.
  - isempty_obstacle=1; rgb_obstacle=0; rom_addr=0; rom_sel=0; anim counter=0; wing frame=Up.
- Slot state: valid, sel[3:0], ox signed 11 bits, oy 10 bits.
- Sprite dimensions (w x h):
  - Cac1S 34x70; Cac2S 68x70; Cac1B 50x100; Cac2B 100x100; Bird 92x80.
  - Bird drawn from row oy+BIRD_OFFSET.
- Spawn:
  - Accepted only when gamestate=01, spawn_sel is legal, and a free slot exists.
  - The lowest-index free slot is loaded with ox=SCR_W, oy=spawn_y, sel=spawn_sel.
  - spawn_ack is asserted the next cycle.
  - Illegal sel or no free slot: request dropped, spawn_ack=0.
- Scroll:
  - On frame_tick with gamestate=01, every valid slot does ox <= ox - speed.
  - A slot is freed in the same update when the new ox + w <= 0.
  - Same-cycle spawn_req and frame_tick: move/retire uses pre-cycle state. The spawn picks a slot free before the cycle, and the new slot is not moved that tick. A slot retiring this cycle cannot be reused until the next cycle.
- Game over (10): positions frozen, animation frozen, pixels still drawn.
- Idle (00): all slots cleared in one cycle (restart); wing frame reset to Up.
- Animation:
  - Counter increments on frame_tick in state 01.
  - At ANIM_FRAMES-1 the counter wraps to 0 and the wing frame toggles.
  - Outside state 01 the Down frame is selected (rom_sel=5).
- Pixel path, cycle n (combinational):
  - Per slot, inside = ox <= x < ox+w and row0 <= y < row0+h, with row0 = oy (bird: oy+BIRD_OFFSET).
  - Comparisons are signed 12-bit; no wrap at the left edge.
  - Priority: the lowest-index slot with inside=1 wins.
  - addr = (x-ox) + (row0+h-1-y)*w, giving a bottom-up row order.
- Pixel path, cycle n+1: rom_addr, rom_sel and a hit flag are registered.
- Pixel path, cycle n+2: outputs registered from rom_data.
  - isempty_obstacle = ~hit OR alpha!=F OR colour not in {FFF, 555}.
  - rgb_obstacle = rom_data[15:4].
  - Total latency from x/y to outputs is 2 cycles.
- A transparent pixel of the winning slot does not reveal lower-priority slots: only one ROM read per pixel.

Test Plan:
- Reset, then gamestate=01 and spawn Cac1S with spawn_y=300 -> spawn_ack one cycle later; active_mask=001; slot ox=640.
- 4 spawns with NUM_SLOTS=3 -> first three acked into slots 0,1,2; fourth spawn_ack=0; active_mask=111.
- speed=10, Cac2B spawned, 75 frame ticks -> after tick 64 ox=0; after tick 74 ox=-100 and slot freed (mask bit clears that cycle).
- Cac1S at ox=100, oy=300, pixel (100,369) with ROM stub returning FFFF -> 2 cycles later rom_addr=0 was issued, isempty=0, rgb=FFF; pixel (134,369) -> isempty=1; ROM 0F0F -> isempty=1.
- Bird, ANIM_FRAMES=8 -> rom_sel alternates 4/5 every 8 frame ticks in state 01; gamestate=10 -> ox frozen, rom_sel=5.
- Overlapping slots 0 and 1 covering the same pixel -> slot 0's sprite select/address used. Same-cycle spawn_req+frame_tick -> new slot keeps ox=640.
